// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD SPI master: FSM states, SPI modes
// and the mode-to-{cpol, cpha} mapping.
package lcd_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP_SW,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'd0;
    localparam logic [1:0] SPI_MODE1 = 2'd1;
    localparam logic [1:0] SPI_MODE2 = 2'd2;
    localparam logic [1:0] SPI_MODE3 = 2'd3;

    // Returns {cpol, cpha} for a standard SPI mode number.
    function automatic logic [1:0] mode_to_cfg(input logic [1:0] mode);
        logic cpol;
        logic cpha;
        cpol = mode[1];
        cpha = mode[0];
        return {cpol, cpha};
    endfunction

endpackage

// File: rtl/lcd_spi_tick_gen.sv
// Half-period timer: down-counter reloaded with div, one-cycle tick every
// div+1 cycles. Clearing restarts a full half-period.
module lcd_spi_tick_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= div;
        end else if (cnt == 8'd0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == 8'd0);

endmodule

// File: rtl/lcd_spi_master.sv
// SPI master for LCD panels: runtime divider, CPOL/CPHA modes, D/C line,
// multiple chip selects with CS hold across words, 3-wire readback.
module lcd_spi_master
    import lcd_spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CS    = 2,
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_dc,
    input  logic              cmd_read,
    input  logic [CS_W-1:0]   cmd_cs,
    input  logic              cmd_last,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spi_sclk,
    output logic [NUM_CS-1:0] spi_ss_n,
    output logic              spi_dc,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    input  logic              spi_sdi
);

    localparam int HW = $clog2(2 * DATA_W);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);

    state_t            state_q, state_n;
    logic              ready_q, ready_n;
    logic [CS_W-1:0]   cs_q, cs_n;
    logic [CS_W-1:0]   held_cs_q, held_cs_n;
    logic              held_q, held_n;
    logic              dcl_q, dcl_n;
    logic              read_q, read_n;
    logic              last_q, last_n;
    logic              cpol_q, cpol_n;
    logic              cpha_q, cpha_n;
    logic [7:0]        div_q, div_n;
    logic [DATA_W-1:0] tx_q, tx_n;
    logic [DATA_W-1:0] rx_q, rx_n;
    logic [HW-1:0]     half_q, half_n;
    logic              sclk_q, sclk_n;
    logic [NUM_CS-1:0] ss_q, ss_n;
    logic              dc_q, dc_n;
    logic              sdo_q, sdo_n;
    logic              oe_q, oe_n;
    logic              rv_q, rv_n;
    logic [DATA_W-1:0] rd_q, rd_n;

    logic              accept, tick, clear, go_setup, lead, upd, smp;
    logic [7:0]        tick_div;
    logic [CS_W-1:0]   src_cs;
    logic [DATA_W-1:0] src_data, tx_shift;
    logic              src_dc, src_read;

    function automatic logic [NUM_CS-1:0] cs_mask(input logic [CS_W-1:0] cs);
        logic [NUM_CS-1:0] m;
        for (int i = 0; i < NUM_CS; i++) m[i] = (int'(cs) != i);
        return m;
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] d);
        return LSB_FIRST ? d[0] : d[DATA_W-1];
    endfunction

    assign accept   = cmd_valid && ready_q;
    // The counter restarts on every state change; in IDLE it must load the
    // divider being accepted, not the previous word's copy.
    assign clear    = (state_n != state_q);
    assign tick_div = (state_q == IDLE) ? cfg_div : div_q;

    lcd_spi_tick_gen u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .div   (tick_div),
        .tick  (tick)
    );

    assign tx_shift = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
    assign lead     = ~half_q[0];
    // CPHA=1 keeps the SETUP bit through the first leading edge; CPHA=0
    // holds the final bit through HOLD instead of shifting past it.
    assign upd      = cpha_q ? (lead && half_q != '0) : (!lead && half_q != LAST_HALF);
    assign smp      = cpha_q ? !lead : lead;

    always_comb begin
        state_n   = state_q;
        cs_n      = cs_q;
        held_cs_n = held_cs_q;
        held_n    = held_q;
        dcl_n     = dcl_q;
        read_n    = read_q;
        last_n    = last_q;
        cpol_n    = cpol_q;
        cpha_n    = cpha_q;
        div_n     = div_q;
        tx_n      = tx_q;
        rx_n      = rx_q;
        half_n    = half_q;
        sclk_n    = sclk_q;
        ss_n      = ss_q;
        dc_n      = dc_q;
        sdo_n     = sdo_q;
        oe_n      = oe_q;
        rv_n      = 1'b0;
        rd_n      = rd_q;
        go_setup  = 1'b0;

        src_cs   = (state_q == IDLE) ? cmd_cs   : cs_q;
        src_data = (state_q == IDLE) ? cmd_data : tx_q;
        src_dc   = (state_q == IDLE) ? cmd_dc   : dcl_q;
        src_read = (state_q == IDLE) ? cmd_read : read_q;

        case (state_q)
            IDLE: begin
                if (!held_q) sclk_n = cfg_cpol;
                if (accept) begin
                    cs_n   = cmd_cs;
                    tx_n   = cmd_data;
                    dcl_n  = cmd_dc;
                    read_n = cmd_read;
                    last_n = cmd_last;
                    div_n  = cfg_div;
                    cpol_n = cfg_cpol;
                    cpha_n = cfg_cpha;
                    held_n = 1'b0;
                    if (held_q && cmd_cs != held_cs_q) begin
                        state_n = GAP_SW;
                        ss_n    = '1;
                        sclk_n  = cfg_cpol;
                    end else begin
                        go_setup = 1'b1;
                    end
                end
            end
            GAP_SW: if (tick) go_setup = 1'b1;
            SETUP: begin
                if (tick) begin
                    state_n = SHIFT;
                    half_n  = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_n = ~sclk_q;
                    half_n = half_q + HW'(1);
                    if (smp) rx_n = LSB_FIRST ? {spi_sdi, rx_q[DATA_W-1:1]}
                                              : {rx_q[DATA_W-2:0], spi_sdi};
                    if (upd && !read_q) begin
                        tx_n  = tx_shift;
                        sdo_n = first_bit(tx_shift);
                    end
                    if (half_q == LAST_HALF) state_n = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    oe_n = 1'b0;
                    if (read_q) begin
                        rv_n = 1'b1;
                        rd_n = rx_q;
                    end
                    if (last_q) begin
                        state_n = GAP;
                        ss_n    = '1;
                        held_n  = 1'b0;
                    end else begin
                        state_n   = IDLE;
                        held_n    = (int'(cs_q) < NUM_CS);
                        held_cs_n = cs_q;
                    end
                end
            end
            GAP: if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (go_setup) begin
            state_n = SETUP;
            ss_n    = cs_mask(src_cs);
            dc_n    = src_dc;
            tx_n    = src_data;
            sdo_n   = src_read ? 1'b0 : first_bit(src_data);
            oe_n    = !src_read;
            rx_n    = '0;
            sclk_n  = (state_q == IDLE) ? cfg_cpol : cpol_q;
        end

        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            cs_q      <= '0;
            held_cs_q <= '0;
            held_q    <= 1'b0;
            dcl_q     <= 1'b0;
            read_q    <= 1'b0;
            last_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= 8'd0;
            tx_q      <= '0;
            rx_q      <= '0;
            half_q    <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= '1;
            dc_q      <= 1'b0;
            sdo_q     <= 1'b0;
            oe_q      <= 1'b0;
            rv_q      <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_n;
            ready_q   <= ready_n;
            cs_q      <= cs_n;
            held_cs_q <= held_cs_n;
            held_q    <= held_n;
            dcl_q     <= dcl_n;
            read_q    <= read_n;
            last_q    <= last_n;
            cpol_q    <= cpol_n;
            cpha_q    <= cpha_n;
            div_q     <= div_n;
            tx_q      <= tx_n;
            rx_q      <= rx_n;
            half_q    <= half_n;
            sclk_q    <= sclk_n;
            ss_q      <= ss_n;
            dc_q      <= dc_n;
            sdo_q     <= sdo_n;
            oe_q      <= oe_n;
            rv_q      <= rv_n;
            rd_q      <= rd_n;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = (state_q != IDLE) || held_q;
    assign rsp_valid  = rv_q;
    assign rsp_data   = rd_q;
    assign spi_sclk   = sclk_q;
    assign spi_ss_n   = ss_q;
    assign spi_dc     = dc_q;
    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = oe_q;

endmodule

// File: tb/tb_lcd_spi_master.sv
// Directed bench for lcd_spi_master: a table of single-word transfers in all
// modes, plus hand sequences for CS chaining, CS switch, reset and divider limits.
module tb_lcd_spi_master;
    import lcd_spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] cfg_div;
    logic       cfg_cpol, cfg_cpha;
    logic       cmd_valid, cmd_ready, cmd_dc, cmd_read, cmd_cs, cmd_last;
    logic [7:0] cmd_data;
    logic       rsp_valid, busy, spi_sclk, spi_dc, spi_sdo, spi_sdo_oe;
    logic [7:0] rsp_data;
    logic [1:0] spi_ss_n;
    logic       spi_sdi = 1'b0;

    logic [7:0]  c16_div;
    logic        c16_valid, c16_ready, c16_rv, c16_busy, c16_sclk, c16_dc, c16_sdo, c16_oe;
    logic [15:0] c16_data, c16_rd;
    logic [1:0]  c16_ss;

    lcd_spi_master #(.DATA_W(8), .NUM_CS(2)) u_dut (
        .clk(clk), .reset(reset), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_dc(cmd_dc),
        .cmd_read(cmd_read), .cmd_cs(cmd_cs), .cmd_last(cmd_last), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
        .spi_dc(spi_dc), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .spi_sdi(spi_sdi)
    );

    lcd_spi_master #(.DATA_W(16), .NUM_CS(2)) u_dut16 (
        .clk(clk), .reset(reset), .cfg_div(c16_div), .cfg_cpol(1'b0), .cfg_cpha(1'b0),
        .cmd_valid(c16_valid), .cmd_ready(c16_ready), .cmd_data(c16_data), .cmd_dc(1'b0),
        .cmd_read(1'b0), .cmd_cs(1'b0), .cmd_last(1'b1), .rsp_valid(c16_rv),
        .rsp_data(c16_rd), .busy(c16_busy), .spi_sclk(c16_sclk), .spi_ss_n(c16_ss),
        .spi_dc(c16_dc), .spi_sdo(c16_sdo), .spi_sdo_oe(c16_oe), .spi_sdi(1'b0)
    );

    int checks = 0;
    int errors = 0;

    // Slave / pin monitor, sampled on the falling clk edge.
    int ss0_low = 0, ss1_low = 0, lead_cnt = 0, oe_cnt = 0, rsp_cnt = 0;
    int ss0_rise = 0, dc_tog = 0, allhigh_run = 0, last_gap = 0, bi = 0;
    logic [31:0] slave_rx = '0;
    logic [7:0]  slave_word = '0;
    logic        prev_sclk = 1'b0, prev_dc = 1'b0;
    logic [1:0]  prev_ss = 2'b11;
    int ss16_low = 0, cyc = 0, rise_idx = 0, r1 = 0, r2 = 0;
    logic prev_sclk16 = 1'b0, prev_ss16 = 1'b1;

    always @(negedge clk) begin : mon
        logic lead;
        cyc++;
        if (!reset) begin
            if (!spi_ss_n[0]) ss0_low++;
            if (!spi_ss_n[1]) ss1_low++;
            if (spi_sdo_oe) oe_cnt++;
            if (rsp_valid) rsp_cnt++;
            if (spi_ss_n[0] && !prev_ss[0]) ss0_rise++;
            if (spi_dc != prev_dc) dc_tog++;
            if (&spi_ss_n) begin
                allhigh_run++;
            end else begin
                if (&prev_ss) begin
                    last_gap = allhigh_run;
                    slave_rx = '0;
                    bi = 0;
                    if (!cfg_cpha) spi_sdi = slave_word[7];
                end
                allhigh_run = 0;
            end
            if (spi_ss_n != 2'b11 && spi_sclk != prev_sclk) begin
                lead = (prev_sclk == cfg_cpol);
                if (lead) lead_cnt++;
                if (lead != cfg_cpha) begin
                    slave_rx = {slave_rx[30:0], spi_sdo};
                end else if (cfg_cpha) begin
                    spi_sdi = slave_word[7-bi];
                    bi++;
                end else begin
                    bi++;
                    if (bi < 8) spi_sdi = slave_word[7-bi];
                end
            end
            if (!c16_ss[0] && prev_ss16) rise_idx = 0;
            if (!c16_ss[0]) begin
                ss16_low++;
                if (c16_sclk && !prev_sclk16) begin
                    if (rise_idx == 0) r1 = cyc;
                    else if (rise_idx == 1) r2 = cyc;
                    rise_idx++;
                end
            end
        end
        prev_sclk   = spi_sclk;
        prev_ss     = spi_ss_n;
        prev_dc     = spi_dc;
        prev_sclk16 = c16_sclk;
        prev_ss16   = c16_ss[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic dc, input logic rd,
                         input logic cs, input logic last);
        int n = 0;
        cmd_data = d; cmd_dc = dc; cmd_read = rd; cmd_cs = cs; cmd_last = last;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_ready8();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while ((busy || !cmd_ready) && n < 20000) begin @(negedge clk); n++; end
        if (busy || !cmd_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run16(input logic [7:0] div, input int exp_len, input int exp_per);
        int n = 0;
        int l0;
        c16_div = div;
        l0 = ss16_low;
        c16_data = 16'hBEEF;
        c16_valid = 1'b1;
        while (!c16_ready && n < 20000) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 c16_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while ((c16_busy || !c16_ready) && n < 20000) begin @(negedge clk); n++; end
        chk("w16_idle", {31'd0, c16_busy}, 32'd0);
        chk("w16_len", ss16_low - l0, exp_len);
        chk("w16_period", r2 - r1, exp_per);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [7:0] div;
        logic       rd;
        logic       cs;
        logic [7:0] sw;
        logic [7:0] exp_word;
        int         exp_len;
    } vec_t;

    vec_t vt[8];

    initial begin
        int l0, l1, le, oe0, rc, r0, d0, n;
        vt[0] = '{8'hA5, SPI_MODE0, 8'd1, 1'b0, 1'b0, 8'h00, 8'hA5, 36};
        vt[1] = '{8'h00, SPI_MODE3, 8'd1, 1'b1, 1'b1, 8'h3C, 8'h3C, 36};
        vt[2] = '{8'h5A, SPI_MODE1, 8'd0, 1'b0, 1'b0, 8'h00, 8'h5A, 18};
        vt[3] = '{8'hC3, SPI_MODE2, 8'd2, 1'b0, 1'b1, 8'h00, 8'hC3, 54};
        vt[4] = '{8'h00, SPI_MODE0, 8'd3, 1'b1, 1'b0, 8'h96, 8'h96, 72};
        vt[5] = '{8'h00, SPI_MODE1, 8'd1, 1'b1, 1'b0, 8'hE1, 8'hE1, 36};
        vt[6] = '{8'h00, SPI_MODE2, 8'd0, 1'b1, 1'b1, 8'h0F, 8'h0F, 18};
        vt[7] = '{8'h3C, SPI_MODE3, 8'd0, 1'b0, 1'b0, 8'h00, 8'h3C, 18};

        reset = 1'b1; cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        cmd_valid = 1'b0; cmd_data = '0; cmd_dc = 1'b0; cmd_read = 1'b0;
        cmd_cs = 1'b0; cmd_last = 1'b1;
        c16_div = 8'd0; c16_valid = 1'b0; c16_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_ss_n", {30'd0, spi_ss_n}, 32'h3);
        chk("rst_pins", {28'd0, spi_sclk, spi_sdo, spi_sdo_oe, spi_dc}, 32'd0);
        chk("rst_rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            {cfg_cpol, cfg_cpha} = mode_to_cfg(vt[i].mode);
            cfg_div = vt[i].div;
            slave_word = vt[i].sw;
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_idle_sclk", i), {31'd0, spi_sclk}, {31'd0, cfg_cpol});
            l0 = ss0_low; l1 = ss1_low; le = lead_cnt; oe0 = oe_cnt; rc = rsp_cnt;
            send8(vt[i].data, 1'b0, vt[i].rd, vt[i].cs, 1'b1);
            wait_idle8();
            chk($sformatf("v%0d_cs_len", i), vt[i].cs ? ss1_low - l1 : ss0_low - l0, vt[i].exp_len);
            chk($sformatf("v%0d_other_cs", i), vt[i].cs ? ss0_low - l0 : ss1_low - l1, 32'd0);
            chk($sformatf("v%0d_leads", i), lead_cnt - le, 32'd8);
            chk($sformatf("v%0d_oe", i), oe_cnt - oe0, vt[i].rd ? 0 : vt[i].exp_len);
            chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt - rc, vt[i].rd ? 1 : 0);
            if (vt[i].rd) chk($sformatf("v%0d_rsp_data", i), {24'd0, rsp_data}, {24'd0, vt[i].exp_word});
            else          chk($sformatf("v%0d_slave_rx", i), {24'd0, slave_rx[7:0]}, {24'd0, vt[i].exp_word});
            chk($sformatf("v%0d_idle_sclk_after", i), {31'd0, spi_sclk}, {31'd0, cfg_cpol});
        end

        // End-of-word gap: ss_n high for D cycles before cmd_ready returns.
        {cfg_cpol, cfg_cpha} = mode_to_cfg(SPI_MODE0);
        cfg_div = 8'd1;
        repeat (2) @(negedge clk);
        send8(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (spi_ss_n[0] && n < 100) begin @(negedge clk); n++; end
        while (!spi_ss_n[0] && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("gap_len", n, 32'd2);
        chk("gap_word", {24'd0, slave_rx[7:0]}, 32'hA5);

        // Chained words on cs0 with a D/C change.
        r0 = ss0_rise; d0 = dc_tog;
        send8(8'h2C, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ready8();
        chk("chain_held_busy", {31'd0, busy}, 32'd1);
        chk("chain_held_cs", {31'd0, spi_ss_n[0]}, 32'd0);
        chk("chain_dc_first", {31'd0, spi_dc}, 32'd0);
        send8(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("chain_dc_setup2", {31'd0, spi_dc}, 32'd1);
        chk("chain_cs_setup2", {31'd0, spi_ss_n[0]}, 32'd0);
        wait_idle8();
        chk("chain_cs_rises", ss0_rise - r0, 32'd1);
        chk("chain_dc_toggles", dc_tog - d0, 32'd1);
        chk("chain_words", {16'd0, slave_rx[15:0]}, 32'h2C55);

        // Held cs0 then a word on cs1: all selects high for D cycles between.
        r0 = ss0_rise; l1 = ss1_low;
        send8(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ready8();
        send8(8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_idle8();
        chk("sw_cs0_rises", ss0_rise - r0, 32'd1);
        chk("sw_gap", last_gap, 32'd2);
        chk("sw_cs1_len", ss1_low - l1, 32'd36);
        chk("sw_word", {24'd0, slave_rx[7:0]}, 32'h22);

        // Reset in the middle of a word, then a clean word.
        le = lead_cnt;
        send8(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (lead_cnt - le < 4 && n < 200) begin @(negedge clk); n++; end
        chk("rst_reach_bit3", {31'd0, (lead_cnt - le >= 4)}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ss_n", {30'd0, spi_ss_n}, 32'h3);
        chk("midrst_pins", {28'd0, spi_sclk, spi_sdo, spi_sdo_oe, spi_dc}, 32'd0);
        chk("midrst_ready_busy", {30'd0, cmd_ready, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
        l0 = ss0_low;
        send8(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle8();
        chk("post_rst_word", {24'd0, slave_rx[7:0]}, 32'h81);
        chk("post_rst_len", ss0_low - l0, 32'd36);

        // 16-bit words at the divider extremes.
        run16(8'd0, 34, 2);
        run16(8'd255, 8704, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_spi_master.md
Name: lcd_spi_master

Overview:
Parametrised SPI master for the MIL LCD panel and similar serial peripherals; the successor to the fixed 8-bit LCD SPI link in the Nios II system.
- Adds runtime clock divider, all four CPOL/CPHA modes, and a D/C (RS) line.
- Adds multiple chip selects, CS hold across chained words, and 3-wire half-duplex readback on the bidirectional SDI pin.
- Sits between an Avalon-ST style command source (CPU bridge or DMA) and the LCD pins.

Parameters:
DATA_W, 8, bits per word (4..32)
NUM_CS, 2, number of active-low chip selects
CS_W, $clog2(NUM_CS) (min 1), width of cmd_cs
LSB_FIRST, 0, 1 = shift LSB first, 0 = MSB first

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_div  in  8  half-period of SCLK is D = cfg_div+1 clk cycles
cfg_cpol  in  1  SCLK idle level
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid && ready
cmd_data  in  DATA_W  word to transmit (ignored if cmd_read)
cmd_dc  in  1  D/C level for this word
cmd_read  in  1  1 = 3-wire read word, SDO released
cmd_cs  in  CS_W  chip-select index
cmd_last  in  1  1 = deassert CS after this word
rsp_valid  out  1  one-cycle pulse, read word complete
rsp_data  out  DATA_W  last read word, held until the next read completes
busy  out  1  high whenever state != IDLE or CS is held
spi_sclk  out  1  serial clock
spi_ss_n  out  NUM_CS  chip selects
spi_dc  out  1  D/C (RS) pin
spi_sdo  out  1  serial out
spi_sdo_oe  out  1  SDI pad output enable (top level tristates the inout)
spi_sdi  in  1  serial in (pad readback)

Behaviour:
Reset values, applied on the clk edge where reset=1, including mid-transfer:
- cmd_ready=0 while reset is high, 1 the cycle after reset is released.
- spi_ss_n all 1, spi_sclk=0, spi_sdo=0, spi_sdo_oe=0, spi_dc=0.
- rsp_valid=0, rsp_data=0, busy=0, state=IDLE, CS-held flag cleared.

Command acceptance:
- cmd_ready=1 only in IDLE.
- On accept, latch cmd_*, cfg_div, cfg_cpol and cfg_cpha; config changes during a word are ignored.
- In IDLE with CS not held, spi_sclk=cfg_cpol.

States:
- IDLE: on accept, if CS is held and cmd_cs differs from the held index, go to GAP_SW; otherwise go to SETUP.
- GAP_SW: all ss_n high for D cycles, then SETUP.
- SETUP (D cycles): ss_n[cs]=0, spi_dc=cmd_dc. First bit driven on spi_sdo, or spi_sdo_oe=0 if read.
- SHIFT (2*DATA_W half-periods of D cycles): SCLK toggles at each half-period boundary.
  - CPHA=0: sample on leading edge, update sdo on trailing edge.
  - CPHA=1: update sdo on leading edge, sample on trailing edge.
  - Exactly DATA_W samples and DATA_W leading edges per word; SCLK ends at cpol.
- HOLD (D cycles): CS still low. Then:
  - if cmd_last: ss_n high, go to GAP (D cycles), then IDLE;
  - else: go to IDLE with CS held low and the CS-held flag set.
- rsp_valid pulses the cycle after HOLD ends, only for read words; no backpressure.

Other rules:
- spi_sdo_oe=1 from SETUP through HOLD on write words, 0 otherwise.
- spi_dc keeps its last value in IDLE.
- Word duration is (2*DATA_W+2)*D cycles; cfg_div=0 gives SCLK = clk/2.
- Bit order is set by LSB_FIRST; the sample shift register uses the same order.
- Invalid cmd_cs (index >= NUM_CS): word shifted with no CS asserted; flag not set.

Decomposition:
- Package lcd_spi_pkg holds:
  - the state enum (IDLE, GAP_SW, SETUP, SHIFT, HOLD, GAP);
  - mode constants SPI_MODE0..3;
  - a function mapping mode to {cpol, cpha}.
- One sub-module, lcd_spi_tick_gen: 8-bit down-counter that reloads with cfg_div and emits a one-cycle half-period tick. It is cleared on reset and on state entry.

Test Plan:
- DATA_W=8, cfg_div=1, mode0, write 0xA5 to cs0, last=1 → spi_sdo reads 1,0,1,0,0,1,0,1 at 8 rising edges; ss_n[0] low for 36 cycles; gap of 2 cycles; cmd_ready high afterwards.
- Mode3 read on cs1, slave drives 0x3C → spi_sdo_oe=0 for the whole word; rsp_valid one pulse with rsp_data=0x3C; spi_sclk idles at 1.
- Chain write 0x2C (dc=0, last=0) then 0x55 (dc=1, last=1) on cs0 → ss_n[0] stays low between words; spi_dc changes only in the second SETUP.
- Chain word on cs0 (last=0), then word on cs1 → ss_n[0] rises, all ss_n high for ≥D cycles, then ss_n[1] falls.
- Assert reset during SHIFT bit 3 → next cycle ss_n=all 1, sclk=0, sdo_oe=0; after release, a 0x81 write completes correctly.
- cfg_div=0 and cfg_div=255 with DATA_W=16 → SCLK period of 2 and 512 cycles; word lengths of 34 and 8704 cycles.
